// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, funct3 encodings and
// the latched per-transaction control word.
package mem_arb_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, WAIT, DONE} arb_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       owner;
    logic       write;
    logic [2:0] func3;
  } arb_ctl_t;

  localparam arb_ctl_t CTL_RST = '{owner: 1'b0, write: 1'b0, func3: F3_W};

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and controller-side signals of the memory arbiter.
// slave = arbiter view, master = requesters plus memory controller.
interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [1:0]                    req_valid;
  logic [1:0]                    req_write;
  logic [1:0][2:0]               req_func3;
  logic [1:0][ADDRESS_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0]    req_wdata;
  logic [1:0]                    req_ready;
  logic [1:0]                    resp_valid;
  logic                          resp_err;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic                          mem_read_En;
  logic                          mem_write_En;
  logic [2:0]                    mem_func3;
  logic [ADDRESS_WIDTH-1:0]      mem_address;
  logic [DATA_WIDTH-1:0]         mem_data_in;
  logic [DATA_WIDTH-1:0]         mem_data_out;
  logic                          mem_ready;

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, mem_data_out, mem_ready,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_read_En, mem_write_En, mem_func3, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, mem_data_out, mem_ready,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_read_En, mem_write_En, mem_func3, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter_rr_grant2.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin single-transaction arbiter in front of the data-memory controller,
// with a watchdog that aborts transactions whose ready handshake never completes.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  arb_state_t              state, state_nxt;
  arb_ctl_t                ctl;
  logic                    last_gnt, abort, resp_err, sel, in_txn, wd_hit, accept;
  logic [1:0]              gnt, req_ready, resp_valid;
  logic [WD_W-1:0]         wd;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;

  rr_grant2 u_rr (.req(bus.req_valid), .last(last_gnt), .gnt(gnt));

  assign sel    = gnt[1];
  assign in_txn = (state == BUSY) || (state == WAIT);
  // Abort decided in the cycle the count reaches its limit, so DONE follows
  // after exactly TIMEOUT_CYCLES cycles in BUSY/WAIT.
  assign wd_hit = in_txn && (wd >= WD_LIM - WD_ONE);
  assign accept = |req_ready;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE:  if (!rst && bus.mem_ready && |bus.req_valid) begin
               req_ready = gnt;
               state_nxt = ISSUE;
             end
      ISSUE: state_nxt = BUSY;
      BUSY:  if (wd_hit) state_nxt = DONE;
             else if (!bus.mem_ready) state_nxt = WAIT;
      WAIT:  if (bus.mem_ready || wd_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ctl        <= CTL_RST;
      last_gnt   <= 1'b1;
      wd         <= '0;
      abort      <= 1'b0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      if (accept) begin
        ctl     <= '{owner: sel, write: bus.req_write[sel], func3: bus.req_func3[sel]};
        addr_q  <= bus.req_addr[sel];
        wdata_q <= bus.req_wdata[sel];
      end
      if (state == ISSUE) wd <= '0;
      else if (in_txn && wd != WD_LIM) wd <= wd + WD_ONE;
      // A ready seen in WAIT wins over a same-cycle watchdog expiry.
      if (in_txn && state_nxt == DONE) abort <= !(state == WAIT && bus.mem_ready);
      if (state == WAIT && bus.mem_ready && !ctl.write) rdata_q <= bus.mem_data_out;
      if (state == DONE) begin
        resp_valid <= ctl.owner ? 2'b10 : 2'b01;
        resp_err   <= abort;
        last_gnt   <= ctl.owner;
      end
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_err     = resp_err;
  assign bus.resp_rdata   = rdata_q;
  assign bus.mem_read_En  = (state == ISSUE) && !ctl.write;
  assign bus.mem_write_En = (state == ISSUE) && ctl.write;
  assign bus.mem_func3    = ctl.func3;
  assign bus.mem_address  = addr_q;
  assign bus.mem_data_in  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory controller with
// programmable latency, negedge monitor, hand-computed expected cycles/data.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Memory controller model: ready drops the cycle after an enable and
  // re-rises lat cycles later; hang keeps it low until reset.
  logic [31:0] mem [16];
  int          m_cnt = 0;
  int          lat   = 2;
  logic        hang  = 1'b0;
  logic [31:0] m_a;

  always @(posedge clk) begin
    if (rst) begin
      bus.mem_ready <= 1'b1;
      m_cnt         <= 0;
      mem[4]        <= 32'hDEADBEEF;
      mem[5]        <= 32'h5555AAAA;
    end else if (bus.mem_read_En || bus.mem_write_En) begin
      bus.mem_ready <= 1'b0;
      m_cnt         <= hang ? 0 : lat;
      m_a           <= bus.mem_address;
      if (bus.mem_write_En) mem[bus.mem_address[5:2]] <= bus.mem_data_in;
    end else if (m_cnt == 1) begin
      bus.mem_ready    <= 1'b1;
      bus.mem_data_out <= mem[m_a[5:2]];
      m_cnt            <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Cycle k spans posedge k .. posedge k+1; the monitor samples mid-cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   acc_cnt [2];
  int   acc_cyc [2];
  int   acc_base[2];
  int   en_cnt = 0, en_cyc = 0, rise_cyc = 0, bad_cnt = 0;
  int   rv_cnt = 0, rv_cyc = 0;
  logic [1:0]  rv_val;
  logic        rv_err;
  logic [31:0] rv_rdata;
  logic        prev_rdy = 1'b1;

  always @(negedge clk) begin
    prev_rdy <= bus.mem_ready;
    if (bus.mem_ready && !prev_rdy) rise_cyc <= cyc;
    for (int p = 0; p < 2; p++)
      if (bus.req_ready[p]) begin
        acc_cnt[p] <= acc_cnt[p] + 1;
        acc_cyc[p] <= cyc;
      end
    if (bus.mem_read_En || bus.mem_write_En) begin
      en_cnt <= en_cnt + 1;
      en_cyc <= cyc;
    end
    if (|bus.resp_valid) begin
      rv_cnt   <= rv_cnt + 1;
      rv_cyc   <= cyc;
      rv_val   <= bus.resp_valid;
      rv_err   <= bus.resp_err;
      rv_rdata <= bus.resp_rdata;
    end
    if ((bus.mem_read_En && bus.mem_write_En) || bus.req_ready == 2'b11 || bus.resp_valid == 2'b11)
      bad_cnt <= bad_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_write[p] = wr;
    bus.req_func3[p] = f3;
    bus.req_addr[p]  = a;
    bus.req_wdata[p] = wd;
    bus.req_valid[p] = 1'b1;
    acc_base[p]      = acc_cnt[p];
  endtask

  task automatic wait_acc(input int p, output int a);
    int n = 0;
    while (acc_cnt[p] == acc_base[p] && n < 30) begin
      step();
      n++;
    end
    chk($sformatf("accept_p%0d", p), acc_cnt[p] != acc_base[p], 1'b1);
    bus.req_valid[p] = 1'b0;
    a = acc_cyc[p];
  endtask

  task automatic wait_resp();
    int base = rv_cnt;
    int n = 0;
    while (rv_cnt == base && n < 40) begin
      step();
      n++;
    end
    chk("resp_seen", rv_cnt != base, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int a, a1, e0, r0, b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_func3 = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    acc_cnt = '{0, 0};
    acc_cyc = '{0, 0};
    acc_base = '{0, 0};

    // Reset values
    step();
    step();
    chk("rst_rd_en",  bus.mem_read_En, 1'b0);
    chk("rst_wr_en",  bus.mem_write_En, 1'b0);
    chk("rst_rvalid", bus.resp_valid, 2'b00);
    chk("rst_err",    bus.resp_err, 1'b0);
    chk("rst_rdata",  bus.resp_rdata, 32'h0);
    chk("rst_addr",   bus.mem_address, 32'h0);
    chk("rst_din",    bus.mem_data_in, 32'h0);
    chk("rst_f3",     bus.mem_func3, 3'b010);
    chk("rst_rready", bus.req_ready, 2'b00);
    rst = 1'b0;
    step();

    // Single load, port 0
    e0 = en_cnt;
    drive(0, 1'b0, F3_W, 32'h10, 32'h0);
    wait_acc(0, a);
    chk("ld_rd_en", bus.mem_read_En, 1'b1);
    chk("ld_wr_en", bus.mem_write_En, 1'b0);
    chk("ld_addr",  bus.mem_address, 32'h10);
    chk("ld_f3",    bus.mem_func3, F3_W);
    wait_resp();
    chk("ld_en_cnt",   en_cnt - e0, 1);
    chk("ld_en_cyc",   en_cyc, a + 1);
    chk("ld_rise_cyc", rise_cyc, a + 4);
    chk("ld_resp_cyc", rv_cyc, rise_cyc + 2);
    chk("ld_owner",    rv_val, 2'b01);
    chk("ld_err",      rv_err, 1'b0);
    chk("ld_rdata",    rv_rdata, 32'hDEADBEEF);

    // Contention after reset: port 0, then port 1, then port 0 again
    do_reset();
    drive(0, 1'b0, F3_W, 32'h10, 32'h0);
    drive(1, 1'b0, F3_W, 32'h14, 32'h0);
    wait_acc(0, a);
    chk("c1_p1_held", acc_cnt[1] == acc_base[1], 1'b1);
    wait_resp();
    chk("c1_p0_owner", rv_val, 2'b01);
    chk("c1_p0_rdata", rv_rdata, 32'hDEADBEEF);
    wait_acc(1, a1);
    chk("c1_p1_acc_cyc", a1, a + 6);
    wait_resp();
    chk("c1_p1_owner", rv_val, 2'b10);
    chk("c1_p1_rdata", rv_rdata, 32'h5555AAAA);
    drive(0, 1'b0, F3_W, 32'h14, 32'h0);
    drive(1, 1'b0, F3_W, 32'h10, 32'h0);
    wait_acc(0, a);
    chk("c2_p1_held", acc_cnt[1] == acc_base[1], 1'b1);
    wait_resp();
    chk("c2_p0_owner", rv_val, 2'b01);
    wait_acc(1, a1);
    wait_resp();
    chk("c2_p1_owner", rv_val, 2'b10);
    chk("c2_p1_rdata", rv_rdata, 32'hDEADBEEF);

    // Store then load on port 1
    drive(1, 1'b1, F3_W, 32'h20, 32'h12345678);
    wait_acc(1, a);
    chk("st_wr_en", bus.mem_write_En, 1'b1);
    chk("st_rd_en", bus.mem_read_En, 1'b0);
    chk("st_din",   bus.mem_data_in, 32'h12345678);
    chk("st_addr",  bus.mem_address, 32'h20);
    wait_resp();
    chk("st_owner", rv_val, 2'b10);
    chk("st_err",   rv_err, 1'b0);
    chk("st_rdata_kept", rv_rdata, 32'hDEADBEEF);
    drive(1, 1'b0, F3_W, 32'h20, 32'h0);
    wait_acc(1, a);
    wait_resp();
    chk("ldst_rdata", rv_rdata, 32'h12345678);

    // Port 1 request withdrawn while port 0 is in flight
    e0 = en_cnt;
    drive(0, 1'b0, F3_W, 32'h14, 32'h0);
    wait_acc(0, a);
    b1 = acc_cnt[1];
    bus.req_addr[1]  = 32'h10;
    bus.req_write[1] = 1'b0;
    bus.req_valid[1] = 1'b1;
    step();
    step();
    bus.req_valid[1] = 1'b0;
    wait_resp();
    for (int i = 0; i < 4; i++) step();
    chk("wd_p1_no_ready", acc_cnt[1], b1);
    chk("wd_one_txn", en_cnt - e0, 1);
    chk("wd_rdata", rv_rdata, 32'h5555AAAA);

    // Reset while in WAIT
    lat = 4;
    drive(0, 1'b0, F3_BU, 32'h24, 32'h0);
    wait_acc(0, a);
    chk("rw_f3_fwd", bus.mem_func3, F3_BU);
    step();
    step();
    step();
    r0  = rv_cnt;
    rst = 1'b1;
    step();
    chk("rw_rvalid", bus.resp_valid, 2'b00);
    chk("rw_rd_en",  bus.mem_read_En, 1'b0);
    chk("rw_f3",     bus.mem_func3, 3'b010);
    chk("rw_addr",   bus.mem_address, 32'h0);
    chk("rw_rdata",  bus.resp_rdata, 32'h0);
    rst = 1'b0;
    lat = 2;
    for (int i = 0; i < 6; i++) step();
    chk("rw_no_resp", rv_cnt, r0);
    drive(0, 1'b0, F3_W, 32'h10, 32'h0);
    wait_acc(0, a);
    wait_resp();
    chk("rw_after_rdata", rv_rdata, 32'hDEADBEEF);
    chk("rw_after_err",   rv_err, 1'b0);

    // Watchdog abort: controller never re-raises ready
    hang = 1'b1;
    e0 = en_cnt;
    drive(0, 1'b0, F3_W, 32'h30, 32'h0);
    wait_acc(0, a);
    wait_resp();
    chk("to_resp_cyc", rv_cyc, a + 11);
    chk("to_owner",    rv_val, 2'b01);
    chk("to_err",      rv_err, 1'b1);
    chk("to_rdata",    rv_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) step();
    chk("to_no_reissue", en_cnt - e0, 1);
    chk("to_rvalid_low", bus.resp_valid, 2'b00);
    hang = 1'b0;
    do_reset();

    chk("protocol_violations", bad_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates single-port access to the data-memory controller between two requesters: port 0, the core load/store unit, and port 1, the program loader/debug port. Grants are round-robin and one transaction is in flight at a time. The arbiter drives the controller's one-cycle read/write enable, tracks the controller's `ready` handshake through busy and back to idle, and returns read data or a write acknowledge to the granted requester. A watchdog aborts transactions that never complete.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width passed to the memory controller.
- `DATA_WIDTH`, 32, data word width.
- `TIMEOUT_CYCLES`, 64, maximum cycles from issue to `mem_ready` re-rising before abort.

Ports:
- `clk`  in  1  single clock. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset. The controller's `rstN` is tied to `~rst` at top level.
- `req_valid`  in  2  per-port request; held high until accepted.
- `req_write`  in  2  per-port: 1 = store, 0 = load.
- `req_func3`  in  2×3  per-port RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  2×ADDRESS_WIDTH  per-port byte address.
- `req_wdata`  in  2×DATA_WIDTH  per-port store data.
- `req_ready`  out  2  one-hot accept pulse; request fields are captured on this cycle.
- `resp_valid`  out  2  one-hot, one-cycle completion pulse to the owning port.
- `resp_err`  out  1  qualifies `resp_valid`; 1 = timeout abort.
- `resp_rdata`  out  DATA_WIDTH  load result; valid with `resp_valid` on loads.
- `mem_read_En`, `mem_write_En`  out  1  controller enables, never both high.
- `mem_func3`  out  3  registered funct3 of the granted request.
- `mem_address`  out  ADDRESS_WIDTH  registered address.
- `mem_data_in`  out  DATA_WIDTH  registered store data.
- `mem_data_out`  in  DATA_WIDTH  controller read data.
- `mem_ready`  in  1  controller idle indicator.

## Operation
- States: `IDLE`, `ISSUE`, `BUSY`, `WAIT`, `DONE`.
- **IDLE**
  - Requires any `req_valid` and `mem_ready`=1.
  - Select the winner: if both ports request, the port not granted last wins; after reset, port 0 has priority.
  - Pulse that port's `req_ready` combinationally and latch func3, address, wdata, write and the owner into registers.
  - Go to `ISSUE`.
- **ISSUE**
  - Assert `mem_read_En` (load) or `mem_write_En` (store) for exactly this cycle.
  - Clear the watchdog and go to `BUSY`.
- **BUSY**: wait for `mem_ready`=0, then go to `WAIT`.
- **WAIT**: on `mem_ready`=1, capture `mem_data_out` into `resp_rdata` (loads only) and go to `DONE`.
- **DONE**
  - Pulse the owner's `resp_valid` with `resp_err`=0.
  - Update the last-grant pointer and return to `IDLE`.
- **Watchdog**
  - Counts every cycle spent in `BUSY` or `WAIT`.
  - When the count reaches `TIMEOUT_CYCLES`: go to `DONE` with `resp_err`=1 and `resp_rdata` unchanged.
- Stores return `resp_valid` as a write acknowledge; `resp_rdata` is not updated.
- funct3 is forwarded unmodified; the arbiter does not decode it.
- Requests arriving while busy are not accepted; requesters must hold `req_valid`.
- Dropping `req_valid` before `req_ready` is legal and withdraws the request.
- `req_ready` is never asserted to both ports in the same cycle.

## Timing
- Reset values:
  - state `IDLE`; last-grant pointer points to port 1, so port 0 has first priority.
  - All enables, `req_ready`, `resp_valid`, `resp_err` = 0.
  - `resp_rdata`, `mem_address`, `mem_data_in` = 0; `mem_func3` = 3'b010.
- Accept at cycle A; enable high at A+1.
- If `mem_ready` re-rises at cycle R, `resp_valid` is high at R+2 (R+1 enters `DONE`).
- Minimum accept-to-accept spacing is 5 cycles.
- Reset mid-transaction:
  - return to `IDLE` next cycle with no `resp_valid`;
  - the pending transaction is lost;
  - the controller is reset in the same cycle.
- Watchdog width: `$clog2(TIMEOUT_CYCLES+1)` bits; it saturates and never wraps.

## Structure
- Package `mem_arb_pkg`: `arb_state_t` enum and funct3 localparams (`F3_B`=3'b000, `F3_H`=3'b001, `F3_W`=3'b010, `F3_BU`=3'b100, `F3_HU`=3'b101).
- Sub-module `rr_grant2`: combinational 2-way round-robin picker. Inputs are request[1:0] and the last-grant bit; output is the one-hot grant. The pointer register stays in `mem_arbiter`.

## Test plan
- **Single load**
  - Stimulus: port 0 LW at address 0x10; memory word = 0xDEADBEEF.
  - Required: `req_ready[0]` at A; `mem_read_En` high at A+1 only; `resp_valid[0]`, `resp_rdata`=0xDEADBEEF, `resp_err`=0 two cycles after `mem_ready` rises.
- **Contention**
  - Stimulus: both ports valid in the same cycle after reset.
  - Required: port 0 granted first. Port 1 is granted at the first `IDLE` after port 0's `DONE`. Next simultaneous pair goes to port 0 again.
- **Back-to-back store then load**
  - Stimulus: port 1 SW 0x12345678 to 0x20, then LW 0x20.
  - Required: write ack with `resp_err`=0, then `resp_rdata`=0x12345678.
- **Timeout**
  - Stimulus: memory model holds `mem_ready`=0 forever after issue; `TIMEOUT_CYCLES`=8.
  - Required: `resp_valid` with `resp_err`=1 eight cycles after entering `BUSY`, then `IDLE`.
- **Reset mid-load**
  - Stimulus: assert `rst` during `WAIT`.
  - Required: no `resp_valid`; all outputs at reset values next cycle; a new request is accepted normally afterward.
- **Withdrawn request**
  - Stimulus: port 1 raises `req_valid` while busy and drops it before `IDLE`.
  - Required: `req_ready[1]` never asserts and no transaction is issued.
